// File: rtl/modred_arbiter.sv
// modred_arbiter
//   Shares one serial modular-reduction engine among NUM_REQ requesters.
//   A round-robin pick in IDLE captures one requester's operands, launches the
//   engine for a single cycle, waits for its done pulse and then holds the
//   result on the shared response bus until the granted requester accepts it.
//
// Parameters
//   NUM_REQ      number of requesters
//   DATA_LENGTH  operand / result width in bits
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester request handshake (ready is one-hot)
//   req_x_i/m_i/m_bl_i    per-requester operand, modulus, modulus bit-length,
//                         packed as NUM_REQ slices of DATA_LENGTH bits
//   rsp_valid_o/ready_i   per-requester response handshake (valid is one-hot)
//   rsp_result_o          shared result, qualified by rsp_valid_o
//   eng_start_o, eng_*_o  engine launch pulse and held operands
//   eng_result_i/valid_i  engine result and single-cycle done pulse
//   busy_o                high whenever a transaction is in flight
//
// Build option
//   MODRED_ARB_BYPASS_EN  when defined, requests with x < m skip the engine
//                         and respond with x directly.

module modred_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_LENGTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_m_bl_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    input  logic [NUM_REQ-1:0]             rsp_ready_i,
    output logic [DATA_LENGTH-1:0]         rsp_result_o,
    output logic                           eng_start_o,
    output logic [DATA_LENGTH-1:0]         eng_x_o,
    output logic [DATA_LENGTH-1:0]         eng_m_o,
    output logic [DATA_LENGTH-1:0]         eng_m_bl_o,
    input  logic [DATA_LENGTH-1:0]         eng_result_i,
    input  logic                           eng_valid_i,
    output logic                           busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [1:0]             state_q,  state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q,  grant_d;
    logic [DATA_LENGTH-1:0] x_q,      x_d;
    logic [DATA_LENGTH-1:0] m_q,      m_d;
    logic [DATA_LENGTH-1:0] m_bl_q,   m_bl_d;
    logic [DATA_LENGTH-1:0] result_q, result_d;

    logic                   found;
    logic [PTR_W-1:0]       sel;
    logic [DATA_LENGTH-1:0] x_sel, m_sel, m_bl_sel;
    logic [NUM_REQ-1:0]     sel_oh, grant_oh;
    logic                   rsp_ack;

    // Round-robin pick: scan offsets 0..NUM_REQ-1 from rr_ptr, first valid wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid_i[i] &&
                    (((32'(rr_ptr_q) + k) % NUM_REQ) == i)) begin
                    found = 1'b1;
                    sel   = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        x_sel    = '0;
        m_sel    = '0;
        m_bl_sel = '0;
        sel_oh   = '0;
        grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == sel) begin
                x_sel     = req_x_i[i*DATA_LENGTH +: DATA_LENGTH];
                m_sel     = req_m_i[i*DATA_LENGTH +: DATA_LENGTH];
                m_bl_sel  = req_m_bl_i[i*DATA_LENGTH +: DATA_LENGTH];
                sel_oh[i] = 1'b1;
            end
            if (PTR_W'(i) == grant_q) begin
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Only the granted requester's ready bit can complete the response.
    assign rsp_ack = |(grant_oh & rsp_ready_i);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        x_d      = x_q;
        m_d      = m_q;
        m_bl_d   = m_bl_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = sel;
                    x_d     = x_sel;
                    m_d     = m_sel;
                    m_bl_d  = m_bl_sel;
`ifdef MODRED_ARB_BYPASS_EN
                    // Already reduced: answer with x and leave the engine idle.
                    if (x_sel < m_sel) begin
                        result_d = x_sel;
                        state_d  = S_RESPOND;
                    end else begin
                        state_d  = S_ISSUE;
                    end
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid_i) begin
                    result_d = eng_result_i;
                    state_d  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_ack) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            x_q      <= '0;
            m_q      <= '0;
            m_bl_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            m_q      <= m_d;
            m_bl_q   <= m_bl_d;
            result_q <= result_d;
        end
    end

    // Control outputs are forced low while reset is asserted, even before the
    // reset edge has returned the state register to IDLE.
    assign req_ready_o  = (!rst_i && state_q == S_IDLE && found) ? sel_oh : '0;
    assign rsp_valid_o  = (!rst_i && state_q == S_RESPOND) ? grant_oh : '0;
    assign eng_start_o  = !rst_i && (state_q == S_ISSUE);
    assign busy_o       = !rst_i && (state_q != S_IDLE);
    assign rsp_result_o = result_q;
    assign eng_x_o      = x_q;
    assign eng_m_o      = m_q;
    assign eng_m_bl_o   = m_bl_q;

endmodule

// File: tb/tb_modred_arbiter.sv
// tb_modred_arbiter
//   Directed bench for modred_arbiter (NUM_REQ=4, DATA_LENGTH=64) with a
//   behavioural engine that returns x % m a programmable number of cycles
//   after each eng_start_o pulse.

module tb_modred_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [N-1:0]     req_valid_i;
    logic [N-1:0]     req_ready_o;
    logic [N*W-1:0]   req_x_i, req_m_i, req_m_bl_i;
    logic [N-1:0]     rsp_valid_o;
    logic [N-1:0]     rsp_ready_i;
    logic [W-1:0]     rsp_result_o;
    logic             eng_start_o;
    logic [W-1:0]     eng_x_o, eng_m_o, eng_m_bl_o;
    logic [W-1:0]     eng_result_i;
    logic             eng_valid_i;
    logic             busy_o;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Engine model
    int unsigned eng_lat   = 10;
    int unsigned eng_cnt   = 0;
    logic [W-1:0] eng_res  = '0;
    logic         man_valid = 1'b0;
    int unsigned starts    = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (eng_start_o) begin
            starts  <= starts + 1;
            eng_cnt <= eng_lat + 1;
            eng_res <= eng_x_o % eng_m_o;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    assign eng_valid_i  = (eng_cnt == 1) | man_valid;
    assign eng_result_i = eng_res;

    modred_arbiter #(.NUM_REQ(N), .DATA_LENGTH(W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_x_i      (req_x_i),
        .req_m_i      (req_m_i),
        .req_m_bl_i   (req_m_bl_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .eng_start_o  (eng_start_o),
        .eng_x_o      (eng_x_o),
        .eng_m_o      (eng_m_o),
        .eng_m_bl_o   (eng_m_bl_o),
        .eng_result_i (eng_result_i),
        .eng_valid_i  (eng_valid_i),
        .busy_o       (busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] m,
                           input logic [W-1:0] bl);
        req_x_i[i*W +: W]    = x;
        req_m_i[i*W +: W]    = m;
        req_m_bl_i[i*W +: W] = bl;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 4'b1111;
        step();
        step();
        vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL rst_ready got=%b exp=0000", req_ready_o); end
        vectors++; if (rsp_valid_o !== 4'b0000) begin miscompares++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid_o); end
        vectors++; if (eng_start_o !== 1'b0) begin miscompares++; $display("FAIL rst_eng_start got=%b exp=0", eng_start_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        vectors++; if ({rsp_result_o, eng_x_o, eng_m_o, eng_m_bl_o} !== '0) begin miscompares++; $display("FAIL rst_regs result=%0d x=%0d m=%0d bl=%0d exp=0", rsp_result_o, eng_x_o, eng_m_o, eng_m_bl_o); end
        rst_i = 1'b0;
        req_valid_i = '0;
        step();
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single();
        int unsigned s0;
        do_reset();
        eng_lat = 10;
        set_req(1, 100, 7, 3);
        req_valid_i = 4'b0010;
        #1;
        vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL single_ready got=%b exp=0010", req_ready_o); end
        s0 = starts;
        step();                               // cycle 1 after accept: ISSUE
        req_valid_i = '0;
        vectors++; if (eng_start_o !== 1'b1) begin miscompares++; $display("FAIL single_start got=%b exp=1", eng_start_o); end
        vectors++; if ({eng_x_o, eng_m_o, eng_m_bl_o} !== {64'd100, 64'd7, 64'd3}) begin miscompares++; $display("FAIL single_ops x=%0d m=%0d bl=%0d exp=100/7/3", eng_x_o, eng_m_o, eng_m_bl_o); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy_o); end
        for (int c = 2; c <= 12; c++) begin
            step();
            vectors++; if ({rsp_valid_o, eng_start_o, eng_x_o} !== {4'b0000, 1'b0, 64'd100}) begin miscompares++; $display("FAIL single_wait c=%0d rsp_valid=%b start=%b x=%0d exp=0000/0/100", c, rsp_valid_o, eng_start_o, eng_x_o); end
        end
        step();                               // cycle 13
        vectors++; if (rsp_valid_o !== 4'b0010) begin miscompares++; $display("FAIL single_rsp_valid got=%b exp=0010", rsp_valid_o); end
        vectors++; if (rsp_result_o !== 64'd2) begin miscompares++; $display("FAIL single_result got=%0d exp=2", rsp_result_o); end
        rsp_ready_i = 4'b0010;
        step();
        rsp_ready_i = '0;
        vectors++; if ({busy_o, rsp_valid_o} !== 5'b0) begin miscompares++; $display("FAIL single_done busy=%b rsp_valid=%b exp=0/0000", busy_o, rsp_valid_o); end
        vectors++; if (starts - s0 !== 1) begin miscompares++; $display("FAIL single_start_count got=%0d exp=1", starts - s0); end
    endtask

    task automatic test_bypass();
        int unsigned s0;
        bit seen;
        eng_lat = 2;
        set_req(0, 5, 7, 3);
        req_valid_i = 4'b0001;
        #1;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL byp_ready got=%b exp=0001", req_ready_o); end
        s0 = starts;
        step();
        req_valid_i = '0;
`ifdef MODRED_ARB_BYPASS_EN
        vectors++; if (rsp_valid_o !== 4'b0001) begin miscompares++; $display("FAIL byp_rsp_valid got=%b exp=0001", rsp_valid_o); end
        vectors++; if (rsp_result_o !== 64'd5) begin miscompares++; $display("FAIL byp_result got=%0d exp=5", rsp_result_o); end
        vectors++; if (eng_start_o !== 1'b0) begin miscompares++; $display("FAIL byp_no_start got=%b exp=0", eng_start_o); end
`else
        vectors++; if (eng_start_o !== 1'b1) begin miscompares++; $display("FAIL eng_path_start got=%b exp=1", eng_start_o); end
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            seen = (rsp_valid_o != '0);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL eng_path_timeout got=no_response exp=response"); end
        vectors++; if ({rsp_valid_o, rsp_result_o} !== {4'b0001, 64'd5}) begin miscompares++; $display("FAIL eng_path_rsp valid=%b result=%0d exp=0001/5", rsp_valid_o, rsp_result_o); end
`endif
        rsp_ready_i = 4'b0001;
        step();
        rsp_ready_i = '0;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL byp_done busy=%b exp=0", busy_o); end
`ifdef MODRED_ARB_BYPASS_EN
        vectors++; if (starts !== s0) begin miscompares++; $display("FAIL byp_start_count got=%0d exp=%0d", starts, s0); end
`else
        vectors++; if (starts - s0 !== 1) begin miscompares++; $display("FAIL eng_path_start_count got=%0d exp=1", starts - s0); end
`endif
    endtask

    task automatic test_round_robin();
        int unsigned  exp_idx [5];
        logic [W-1:0] exp_res [4];
        logic [N-1:0] exp_oh;
        bit seen;
        exp_idx = '{0, 1, 2, 3, 0};
        exp_res = '{64'd2, 64'd5, 64'd12, 64'd7};
        eng_lat = 3;
        set_req(0, 100, 7, 3);
        set_req(1, 50, 9, 4);
        set_req(2, 1000, 13, 4);
        set_req(3, 77, 10, 4);
        req_valid_i = 4'b1111;
        rsp_ready_i = 4'b1111;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                step();
                seen = (rsp_valid_o != '0);
            end
            vectors++; if (!seen) begin miscompares++; $display("FAIL rr_timeout g=%0d got=no_response exp=response", g); end
            exp_oh = '0;
            exp_oh[exp_idx[g]] = 1'b1;
            vectors++; if (rsp_valid_o !== exp_oh) begin miscompares++; $display("FAIL rr_order g=%0d got=%b exp=%b", g, rsp_valid_o, exp_oh); end
            vectors++; if (rsp_result_o !== exp_res[exp_idx[g]]) begin miscompares++; $display("FAIL rr_result g=%0d got=%0d exp=%0d", g, rsp_result_o, exp_res[exp_idx[g]]); end
            step();
        end
        req_valid_i = '0;
        rsp_ready_i = '0;
        step();
    endtask

    task automatic test_back_pressure();
        bit seen;
        do_reset();
        eng_lat = 3;
        set_req(2, 1000, 13, 4);
        req_valid_i = 4'b0100;
        rsp_ready_i = 4'b1011;               // non-granted readies must be ignored
        #1;
        vectors++; if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL bp_ready got=%b exp=0100", req_ready_o); end
        step();
        req_valid_i = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            seen = (rsp_valid_o != '0);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL bp_timeout got=no_response exp=response"); end
        for (int c = 0; c < 5; c++) begin
            vectors++; if ({rsp_valid_o, rsp_result_o, req_ready_o} !== {4'b0100, 64'd12, 4'b0000}) begin miscompares++; $display("FAIL bp_hold c=%0d valid=%b result=%0d ready=%b exp=0100/12/0000", c, rsp_valid_o, rsp_result_o, req_ready_o); end
            step();
        end
        rsp_ready_i = 4'b1111;
        #1;
        vectors++; if ({rsp_valid_o, req_ready_o} !== {4'b0100, 4'b0000}) begin miscompares++; $display("FAIL bp_handshake valid=%b ready=%b exp=0100/0000", rsp_valid_o, req_ready_o); end
        step();
        vectors++; if (req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL bp_next_ptr got=%b exp=1000", req_ready_o); end
        req_valid_i = '0;
        rsp_ready_i = '0;
        step();
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset();
        eng_lat = 10;
        set_req(1, 100, 7, 3);
        req_valid_i = 4'b0010;
        #1;
        step();                               // ISSUE
        req_valid_i = '0;
        step();                               // WAIT 1
        step();                               // WAIT 2
        step();                               // WAIT 3
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rm_in_wait busy=%b exp=1", busy_o); end
        rst_i = 1'b1;
        req_valid_i = 4'b1111;
        #1;
        vectors++; if ({req_ready_o, rsp_valid_o, eng_start_o, busy_o} !== 10'b0) begin miscompares++; $display("FAIL rm_during_rst ready=%b valid=%b start=%b busy=%b exp=0", req_ready_o, rsp_valid_o, eng_start_o, busy_o); end
        step();
        rst_i = 1'b0;
        req_valid_i = '0;
        bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (rsp_valid_o != '0 || busy_o) bad = 1'b1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL rm_abandon got=response_or_busy exp=idle"); end
        vectors++; if (rsp_result_o !== '0) begin miscompares++; $display("FAIL rm_result got=%0d exp=0", rsp_result_o); end
        req_valid_i = 4'b1111;
        #1;
        vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL rm_ptr got=%b exp=0001", req_ready_o); end
        req_valid_i = '0;
        step();
    endtask

    task automatic test_spurious();
        req_valid_i = '0;
        man_valid = 1'b1;
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL spur_busy0 got=%b exp=0", busy_o); end
        step();
        man_valid = 1'b0;
        vectors++; if ({busy_o, rsp_valid_o} !== 5'b0) begin miscompares++; $display("FAIL spur_after1 busy=%b valid=%b exp=0/0000", busy_o, rsp_valid_o); end
        step();
        vectors++; if ({busy_o, rsp_valid_o} !== 5'b0) begin miscompares++; $display("FAIL spur_after2 busy=%b valid=%b exp=0/0000", busy_o, rsp_valid_o); end
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_x_i     = '0;
        req_m_i     = {N{64'd1}};
        req_m_bl_i  = '0;
        test_reset();
        test_single();
        test_bypass();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
